// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module   : fetch_unit_pkg
// Brief    : Shared state encodings and instruction constants for fetch/decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = {25'd0, OPC_OP_IMM};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  function automatic logic is_ctrl_flow(input logic [6:0] opcode);
    return (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Instruction-memory port and decoder handshake bundle of the fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if #(
  parameter int N = 32
);
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [N-1:0] imem_rdata;
  logic [N-1:0] instr;
  logic [N-1:0] pc;
  logic         instr_valid;
  logic         instr_ready;
  logic         pc_sel;
  logic [N-1:0] pc_target;
  logic         fetch_fault;

  modport master (
    output imem_req, imem_addr, instr, pc, instr_valid, fetch_fault,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, pc_sel, pc_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, pc, instr_valid, fetch_fault,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, pc_sel, pc_target
  );
endinterface

`default_nettype wire

// File: rtl/fetch_pc_gen.sv
// ============================================================================
// Module   : fetch_pc_gen
// Brief    : PC register with +4 increment, redirect load and alignment check.
//            FETCH_MISALIGN_EN: keep raw target and flag misalignment.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_pc_gen #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [N-1:0] target,
`ifdef FETCH_MISALIGN_EN
  output logic         misaligned,
`endif
  output logic [N-1:0] pc
);

  localparam logic [N-1:0] ALIGN_MASK = {{(N-2){1'b1}}, 2'b00};

  logic [N-1:0] pc_q;
  logic [N-1:0] pc_d;
  logic [N-1:0] target_eff;

`ifdef FETCH_MISALIGN_EN
  // The faulting target is kept verbatim so it stays visible on pc.
  assign target_eff = target;
  assign misaligned = |target[1:0];
`else
  assign target_eff = target & ALIGN_MASK;
`endif

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = target_eff;
    end else if (inc) begin
      pc_d = pc_q + N'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage, one outstanding imem read, redirect aware.
//            FETCH_MISALIGN_EN: misaligned redirect enters sticky FAULT state.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  fetch_state_e state_q, state_d;
  logic         drop_q, drop_d;
  logic [N-1:0] instr_q, instr_d;
  logic         redirect;
  logic         pc_inc;
  logic [N-1:0] pc_cur;

  assign redirect = bus.pc_sel &&
                    ((state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_HOLD));

`ifdef FETCH_MISALIGN_EN
  logic target_misaligned;
`endif

  fetch_pc_gen #(
    .N        (N),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk        (clk),
    .rst        (rst),
    .inc        (pc_inc),
    .load       (redirect),
    .target     (bus.pc_target),
`ifdef FETCH_MISALIGN_EN
    .misaligned (target_misaligned),
`endif
    .pc         (pc_cur)
  );

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    instr_d = instr_q;
    pc_inc  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        // A redirect coincident with the grant means the issued read used the old pc.
        if (bus.imem_gnt) begin
          state_d = ST_WAIT;
          drop_d  = redirect;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            instr_d = bus.imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_REQ;
        end else if (bus.instr_ready) begin
          pc_inc  = 1'b1;
          state_d = ST_REQ;
        end
      end
      default: state_d = state_q;
    endcase
`ifdef FETCH_MISALIGN_EN
    if (redirect && target_misaligned) begin
      state_d = ST_FAULT;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
      instr_q <= N'(NOP);
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      instr_q <= instr_d;
    end
  end

  assign bus.imem_req    = (state_q == ST_REQ);
  assign bus.imem_addr   = pc_cur;
  assign bus.instr       = instr_q;
  assign bus.pc          = pc_cur;
  assign bus.instr_valid = (state_q == ST_HOLD);
`ifdef FETCH_MISALIGN_EN
  assign bus.fetch_fault = (state_q == ST_FAULT);
`else
  assign bus.fetch_fault = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  fetch_unit_if #(.N(32)) bus ();

  fetch_unit #(.N(32), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (actual running, required done)");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.instr_ready = 1'b0; bus.pc_sel = 1'b0; bus.pc_target = '0;
    tick(); tick();
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req actual=%b required=0", bus.imem_req); end
    n_vec++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr actual=%h required=00000000", bus.imem_addr); end
    n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid actual=%b required=0", bus.instr_valid); end
    n_vec++; if (bus.instr !== NOP_W) begin n_err++; $display("FAIL rst_instr actual=%h required=%h", bus.instr, NOP_W); end
    n_vec++; if (bus.fetch_fault !== 1'b0) begin n_err++; $display("FAIL rst_fault actual=%b required=0", bus.fetch_fault); end
    rst = 1'b0;
    tick();
    n_vec++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL idle_to_req actual=%b required=1", bus.imem_req); end
  endtask

  // Full-speed stream: gnt in REQ, rvalid the cycle after, decoder always ready.
  task automatic test_stream();
    logic [31:0] a;
    logic [31:0] d;
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 32'(k) * 32'd4;
      d = 32'hA000_0000 + a;
      n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== a) begin n_err++; $display("FAIL stream_req%0d actual=%b/%h required=1/%h", k, bus.imem_req, bus.imem_addr, a); end
      n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL stream_novalid_req%0d actual=%b required=0", k, bus.instr_valid); end
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = d;
      n_vec++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL stream_wait%0d actual=%b/%b required=0/0", k, bus.imem_req, bus.instr_valid); end
      tick();
      bus.imem_rvalid = 1'b0;
      n_vec++; if (bus.instr_valid !== 1'b1 || bus.instr !== d || bus.pc !== a) begin n_err++; $display("FAIL stream_hold%0d actual=%b/%h/%h required=1/%h/%h", k, bus.instr_valid, bus.instr, bus.pc, d, a); end
      tick();
    end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    apply_reset();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL stall%0d actual=%b/%h required=1/00000000", k, bus.imem_req, bus.imem_addr); end
      tick();
    end
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0093;
    tick();
    bus.imem_rvalid = 1'b0;
    n_vec++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0000_0093) begin n_err++; $display("FAIL stall_hold actual=%b/%h required=1/00000093", bus.instr_valid, bus.instr); end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    n_vec++; if (bus.imem_addr !== 32'h4) begin n_err++; $display("FAIL stall_next actual=%h required=00000004", bus.imem_addr); end
  endtask

  task automatic test_redirect_wait();
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0; bus.pc_sel = 1'b1; bus.pc_target = 32'h100;
    tick();
    bus.pc_sel = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rdw_wait actual=%b required=0", bus.imem_req); end
    tick();
    bus.imem_rvalid = 1'b0;
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL rdw_req actual=%b/%h required=1/00000100", bus.imem_req, bus.imem_addr); end
    n_vec++; if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0000_0093) begin n_err++; $display("FAIL rdw_dropped actual=%b/%h required=0/00000093", bus.instr_valid, bus.instr); end
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0010_0113;
    tick();
    bus.imem_rvalid = 1'b0;
    n_vec++; if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h100 || bus.instr !== 32'h0010_0113) begin n_err++; $display("FAIL rdw_hold actual=%b/%h/%h required=1/00000100/00100113", bus.instr_valid, bus.pc, bus.instr); end
  endtask

  task automatic test_redirect_hold();
    bus.instr_ready = 1'b0; bus.pc_sel = 1'b1; bus.pc_target = 32'h40;
    tick();
    bus.pc_sel = 1'b0;
    n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rdh_valid actual=%b required=0", bus.instr_valid); end
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin n_err++; $display("FAIL rdh_req actual=%b/%h required=1/00000040", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_redirect_req_gnt();
    bus.imem_gnt = 1'b1; bus.pc_sel = 1'b1; bus.pc_target = 32'h200;
    tick();
    bus.imem_gnt = 1'b0; bus.pc_sel = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
    tick();
    bus.imem_rvalid = 1'b0;
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200 || bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rdg_req actual=%b/%h/%b required=1/00000200/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
  endtask

  task automatic test_reset_in_wait();
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0; rst = 1'b1;
    tick();
    n_vec++; if (bus.imem_req !== 1'b0 || bus.instr !== NOP_W) begin n_err++; $display("FAIL riw_rst actual=%b/%h required=0/%h", bus.imem_req, bus.instr, NOP_W); end
    rst = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h5555_5555;
    tick(); tick();
    bus.imem_rvalid = 1'b0;
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL riw_req actual=%b/%h required=1/00000000", bus.imem_req, bus.imem_addr); end
    n_vec++; if (bus.instr !== NOP_W || bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL riw_stale actual=%h/%b required=%h/0", bus.instr, bus.instr_valid, NOP_W); end
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0020_0193;
    tick();
    bus.imem_rvalid = 1'b0;
    n_vec++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0020_0193 || bus.pc !== 32'h0) begin n_err++; $display("FAIL riw_first actual=%b/%h/%h required=1/00200193/00000000", bus.instr_valid, bus.instr, bus.pc); end
  endtask

  task automatic test_misalign();
    bus.instr_ready = 1'b0; bus.pc_sel = 1'b1; bus.pc_target = 32'h102;
    tick();
    bus.pc_sel = 1'b0;
`ifdef FETCH_MISALIGN_EN
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (bus.fetch_fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL mis_fault%0d actual=%b/%b/%b required=1/0/0", k, bus.fetch_fault, bus.imem_req, bus.instr_valid); end
      n_vec++; if (bus.pc !== 32'h102) begin n_err++; $display("FAIL mis_pc%0d actual=%h required=00000102", k, bus.pc); end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (bus.fetch_fault !== 1'b0) begin n_err++; $display("FAIL mis_clear actual=%b required=0", bus.fetch_fault); end
`else
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.fetch_fault !== 1'b0) begin n_err++; $display("FAIL mis_align actual=%b/%h/%b required=1/00000100/0", bus.imem_req, bus.imem_addr, bus.fetch_fault); end
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_req_gnt();
    test_reset_in_wait();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
